// File: rtl/sub_seq_ctrl_if.sv
// Start/done handshake and operand/result bus for the nibble-serial subtractor.
// master drives the request side; slave is the sub_seq_ctrl side.
interface sub_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, zero
    );
endinterface

// File: rtl/sub_seq_ctrl.sv
// Multi-cycle WIDTH-bit subtractor d = a - b - bin, one 4-bit ripple-borrow nibble per clock.
// Optional macro SUB_SEQ_SAT_EN: unsigned saturation of d to 0 on a final borrow.
module sub_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    sub_seq_ctrl_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IdxW   = $clog2(NSLICE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic [3:0]       a_nib, b_nib, slice_d;
    logic [4:0]       bchain;
    logic             slice_bo;
    logic [WIDTH-1:0] res_wrap, res;

    // Ripple-borrow slice on the current nibble.
    always_comb begin
        a_nib     = a_q[{idx_q, 2'b00} +: 4];
        b_nib     = b_q[{idx_q, 2'b00} +: 4];
        bchain    = '0;
        bchain[0] = br_q;
        slice_d   = '0;
        for (int i = 0; i < 4; i++) begin
            slice_d[i]    = a_nib[i] ^ b_nib[i] ^ bchain[i];
            bchain[i + 1] = (~a_nib[i] & b_nib[i]) | (bchain[i] & ~(a_nib[i] ^ b_nib[i]));
        end
        slice_bo = bchain[4];
    end

    // Full result as it stands once the current nibble is merged in.
    always_comb begin
        res_wrap = acc_q;
        res_wrap[{idx_q, 2'b00} +: 4] = slice_d;
`ifdef SUB_SEQ_SAT_EN
        res = slice_bo ? '0 : res_wrap;
`else
        res = res_wrap;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        acc_d   = acc_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    idx_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d = res_wrap;
                br_d  = slice_bo;
                idx_d = idx_q + 1'b1;
                // Outputs change only on entry to DONE so d stays stable mid-run.
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    d_d     = res;
                    bout_d  = slice_bo;
                    zero_d  = (res == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            acc_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl (WIDTH=16): latency, arithmetic corners, ignored start,
// back-to-back start in DONE, and mid-run reset.
module tb_sub_seq_ctrl;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sub_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply saturation to a wrapped expectation when the feature is built in.
    task automatic expect_res(input logic [15:0] wd, input logic wb,
                              output logic [15:0] ed, output logic ez);
`ifdef SUB_SEQ_SAT_EN
        ed = wb ? 16'h0000 : wd;
`else
        ed = wd;
`endif
        ez = (ed == 16'h0000);
    endtask

    // Each sample is taken 1 time unit after a rising edge; k counts edges after the accept edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] wd, input logic wb);
        logic [15:0] ed;
        logic        ez;
        int          n_done;
        int          done_at;
        int          busy_cnt;
        logic [15:0] d_seen;
        logic        bout_seen;
        logic        zero_seen;
        expect_res(wd, wb, ed, ez);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        n_done    = 0;
        done_at   = -1;
        busy_cnt  = 0;
        d_seen    = '0;
        bout_seen = 1'b0;
        zero_seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                n_done++;
                done_at   = k;
                d_seen    = bus.d;
                bout_seen = bus.bout;
                zero_seen = bus.zero;
            end
            @(posedge clk);
            #1;
        end
        check({tag, ".done_cnt"}, n_done, 1);
        check({tag, ".done_at"}, done_at, 4);
        check({tag, ".busy_cnt"}, busy_cnt, 4);
        check({tag, ".d"}, d_seen, ed);
        check({tag, ".bout"}, bout_seen, wb);
        check({tag, ".zero"}, zero_seen, ez);
        check({tag, ".d_held"}, bus.d, ed);
    endtask

    initial begin
        logic [15:0] ed;
        logic        ez;
        int          n_done;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.d", bus.d, 0);
        check("rst.bout", bus.bout, 0);
        check("rst.zero", bus.zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
        run_op("v2", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0);
        run_op("v3", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);

        // Mid-run reset: rst_n sampled low at the third edge after acceptance.
        run_op("v4", 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0);
        bus.start = 1'b1;
        bus.a     = 16'h4321;
        bus.b     = 16'h0001;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst.busy", bus.busy, 0);
        check("mrst.done", bus.done, 0);
        check("mrst.d", bus.d, 0);
        rst_n  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("mrst.no_done", n_done, 0);
        check("mrst.d_after", bus.d, 0);
        run_op("v5", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1);
        run_op("v6", 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0);
        run_op("v7", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Start during a run is ignored; start in DONE launches the next op back-to-back.
        bus.start = 1'b1;
        bus.a     = 16'h1234;
        bus.b     = 16'h0234;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b.busy_k2", bus.busy, 1);
        repeat (2) @(posedge clk);
        #1;
        check("b2b.done1", bus.done, 1);
        check("b2b.d1", bus.d, 16'h1000);
        bus.start = 1'b1;
        bus.a     = 16'h1000;
        bus.b     = 16'h0001;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b.done_k5", bus.done, 0);
        check("b2b.busy_k5", bus.busy, 1);
        repeat (2) @(posedge clk);
        #1;
        check("b2b.d_midrun", bus.d, 16'h1000);
        @(posedge clk);
        #1;
        check("b2b.done_k8", bus.done, 0);
        @(posedge clk);
        #1;
        expect_res(16'h0FFF, 1'b0, ed, ez);
        check("b2b.done2", bus.done, 1);
        check("b2b.d2", bus.d, ed);
        check("b2b.zero2", bus.zero, ez);
        @(posedge clk);
        #1;
        check("b2b.done_off", bus.done, 0);
        check("b2b.idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
